// File: rtl/video_coord_tagger_if.sv
// Beat stream bundle for video_coord_tagger: AXI-style video input plus coordinate-tagged output.
// slave = tagger view, master = source/sink view.
interface video_coord_tagger_if #(
    parameter int DATA_WIDTH = 8,
    parameter int X_WIDTH    = 12,
    parameter int Y_WIDTH    = 12
);
    logic                  s_vtvalid;
    logic [DATA_WIDTH-1:0] s_vtdata;
    logic                  s_vtlast;
    logic                  s_vtready;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic [X_WIDTH-1:0]    m_x;
    logic [Y_WIDTH-1:0]    m_y;
    logic                  m_sof;
    logic                  m_eol;
    logic                  m_eof;
    logic                  m_ready;

    modport slave (
        input  s_vtvalid, s_vtdata, s_vtlast, m_ready,
        output s_vtready, m_valid, m_data, m_x, m_y, m_sof, m_eol, m_eof
    );

    modport master (
        output s_vtvalid, s_vtdata, s_vtlast, m_ready,
        input  s_vtready, m_valid, m_data, m_x, m_y, m_sof, m_eol, m_eof
    );
endinterface

// File: rtl/video_coord_tagger.sv
// Tags video beats with x/y and SOF/EOL/EOF, flags early/late tlast; 1-cycle latency, full throughput.
// Backpressure: 2-entry skid buffer, s_vtready registered. Optional counters: VIDEO_COORD_TAGGER_ERRCNT_EN.
module video_coord_tagger #(
    parameter int DATA_WIDTH = 8,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int X_WIDTH    = 12,
    parameter int Y_WIDTH    = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    video_coord_tagger_if.slave vif,
    output logic err_early,
    output logic err_late,
    output logic frame_done
`ifdef VIDEO_COORD_TAGGER_ERRCNT_EN
    ,
    output logic [15:0] err_early_cnt,
    output logic [15:0] err_late_cnt
`endif
);
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;
    localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(H_ACTIVE - 1);
    localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(V_ACTIVE - 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [X_WIDTH-1:0]    x;
        logic [Y_WIDTH-1:0]    y;
        logic                  sof;
        logic                  eol;
        logic                  eof;
    } beat_t;

    logic               state, state_nxt;
    logic [1:0]         occ, occ_nxt;
    logic               ready_q;
    logic [X_WIDTH-1:0] x;
    logic [Y_WIDTH-1:0] y;
    beat_t              head, tail, in_beat;
    logic               acc, ret, x_last, y_last, line_end;

    assign acc      = vif.s_vtvalid & ready_q;
    assign ret      = (occ != 2'd0) & vif.m_ready;
    assign x_last   = (x == X_LAST);
    assign y_last   = (y == Y_LAST);
    assign line_end = vif.s_vtlast | x_last;
    assign occ_nxt  = occ + {1'b0, acc} - {1'b0, ret};

    always_comb begin
        in_beat      = '0;
        in_beat.data = vif.s_vtdata;
        in_beat.x    = x;
        in_beat.y    = y;
        in_beat.sof  = (x == '0) && (y == '0);
        in_beat.eol  = line_end;
        in_beat.eof  = line_end & y_last;
    end

    // en only matters at frame boundaries: leaving IDLE, or on the accepted EOF beat
    always_comb begin
        state_nxt = state;
        if (state == ST_IDLE) begin
            if (en) state_nxt = ST_RUN;
        end else if (acc && in_beat.eof && !en) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            occ        <= 2'd0;
            ready_q    <= 1'b0;
            x          <= '0;
            y          <= '0;
            head       <= '0;
            tail       <= '0;
            err_early  <= 1'b0;
            err_late   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            occ     <= occ_nxt;
            // Ready follows next occupancy so a full buffer never sees another accept
            ready_q <= (state_nxt == ST_RUN) && (occ_nxt < 2'd2);

            if (ret) begin
                if (occ == 2'd2) head <= tail;
                else if (acc)    head <= in_beat;
                if (occ == 2'd2 && acc) tail <= in_beat;
            end else if (acc) begin
                if (occ == 2'd0) head <= in_beat;
                else             tail <= in_beat;
            end

            if (acc) begin
                if (line_end) begin
                    x <= '0;
                    y <= y_last ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end

            err_early  <= acc & vif.s_vtlast & ~x_last;
            err_late   <= acc & ~vif.s_vtlast & x_last;
            frame_done <= acc & in_beat.eof;
        end
    end

`ifdef VIDEO_COORD_TAGGER_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_early_cnt <= 16'd0;
            err_late_cnt  <= 16'd0;
        end else begin
            if (err_early && err_early_cnt != 16'hFFFF) err_early_cnt <= err_early_cnt + 16'd1;
            if (err_late && err_late_cnt != 16'hFFFF)   err_late_cnt  <= err_late_cnt + 16'd1;
        end
    end
`endif

    assign vif.s_vtready = ready_q;
    assign vif.m_valid   = (occ != 2'd0);
    assign vif.m_data    = head.data;
    assign vif.m_x       = head.x;
    assign vif.m_y       = head.y;
    assign vif.m_sof     = head.sof;
    assign vif.m_eol     = head.eol;
    assign vif.m_eof     = head.eof;
endmodule
